// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I decode stage with valid/ready on both
// sides and a 2-entry skid buffer of decoded entries.
// Optional feature macro: DECODE_ILLEGAL_EN (illegal-instruction flag).
module rv_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic [PC_W-1:0] out_pc,
  output logic            illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_UNK = 3'd7;

  // Decoded entry storage; the instruction word itself carries the raw fields.
  logic [31:0]     r_instr [2];
  logic [XLEN-1:0] r_imm   [2];
  logic [2:0]      r_fmt   [2];
  logic [PC_W-1:0] r_pc    [2];
  logic            r_ill   [2];

  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;
  logic       r_in_ready;

  logic [2:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_ill;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_count_next;

  // Classify the incoming instruction format from its opcode.
  always_comb begin
    w_fmt = FMT_UNK;
    case (in_instr[6:0])
      7'b0110011:                                     w_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: w_fmt = FMT_I;
      7'b0100011:                                     w_fmt = FMT_S;
      7'b1100011:                                     w_fmt = FMT_B;
      7'b0110111, 7'b0010111:                         w_fmt = FMT_U;
      7'b1101111:                                     w_fmt = FMT_J;
      default:                                        w_fmt = FMT_UNK;
    endcase
  end

  // Assemble the 32-bit sign-extended immediate for the decoded format.
  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FMT_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      FMT_U: w_imm32 = {in_instr[31:12], 12'b0};
      FMT_J: w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Widen to XLEN by replicating bit 31 when XLEN exceeds 32.
  generate
    if (XLEN > 32) begin : g_imm_wide
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_narrow
      assign w_imm = w_imm32[XLEN-1:0];
    end
  endgenerate

`ifdef DECODE_ILLEGAL_EN
  assign w_ill = (in_instr[1:0] != 2'b11) || (w_fmt == FMT_UNK) ||
                 (in_instr == 32'h0000_0000) || (in_instr == 32'hFFFF_FFFF);
`else
  assign w_ill = 1'b0;
`endif

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = (r_count != 2'd0) && out_ready;

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + 2'd1;
    else if (!w_push && w_pop)
      w_count_next = r_count - 2'd1;
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != 2'd2);
    end
  end

  // Per-entry storage; cleared on reset so outputs read as zero / UNK.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      // Capture the decoded instruction into this slot when it is the tail.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_instr[gi] <= '0;
          r_imm[gi]   <= '0;
          r_fmt[gi]   <= FMT_UNK;
          r_pc[gi]    <= '0;
          r_ill[gi]   <= 1'b0;
        end else if (w_push && (r_tail == gi[0])) begin
          r_instr[gi] <= in_instr;
          r_imm[gi]   <= w_imm;
          r_fmt[gi]   <= w_fmt;
          r_pc[gi]    <= in_pc;
          r_ill[gi]   <= w_ill;
        end
      end
    end
  endgenerate

  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign opcode    = r_instr[r_head][6:0];
  assign rd        = r_instr[r_head][11:7];
  assign funct3    = r_instr[r_head][14:12];
  assign rs1       = r_instr[r_head][19:15];
  assign rs2       = r_instr[r_head][24:20];
  assign funct7    = r_instr[r_head][31:25];
  assign imm       = r_imm[r_head];
  assign fmt       = r_fmt[r_head];
  assign out_pc    = r_pc[r_head];
  assign illegal   = r_ill[r_head];

endmodule
